// File: rtl/aes_encipher_core_pkg.sv
// Shared definitions for the iterative AES encipher core.
// Contents:
//   KEYLEN_128 / KEYLEN_256  - keylen encodings
//   NR_128 / NR_256          - round counts (10 / 14)
//   ST_*                     - round FSM state encoding
//   gm2 / gm3                - GF(2^8) multiply by 2 and 3
//   shiftrows                - AES ShiftRows on a 128-bit state
// State byte n (n = 4*column + row) sits at bits [127-8n -: 8], so
// bits [127:96] hold column 0.
package aes_encipher_core_pkg;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_INIT   = 3'd1;
    localparam state_t ST_SBOX   = 3'd2;
    localparam state_t ST_MAIN   = 3'd3;
    localparam state_t ST_FINAL  = 3'd4;
    localparam state_t ST_MAIN_A = 3'd5;
    localparam state_t ST_MAIN_B = 3'd6;

    // Byte view of the state; element 0 is the most significant byte.
    typedef logic [0:15][7:0] aes_bytes_t;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    // Row r is rotated left by r columns.
    function automatic aes_bytes_t shiftrows(input aes_bytes_t s);
        aes_bytes_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[4*c + row] = s[4*((c + row) % 4) + row];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_encipher_core_if.sv
// Bundle of the encipher core's host, key-memory and S-box bank signals.
// Signals:
//   next, keylen, block   - start pulse, key length, plaintext
//   new_block, ready      - state / ciphertext and idle flag
//   round, round_key      - round key request and same-cycle return
//   sboxw, new_sboxw      - S-box bank inputs and same-cycle outputs
// The master side is the surrounding system (host, key memory and
// S-box bank); the slave side is the encipher core.
interface aes_encipher_core_if #(
    parameter int SBOX_LANES = 1
);

    logic                      next;
    logic                      keylen;
    logic [127:0]              block;
    logic [127:0]              new_block;
    logic                      ready;
    logic [3:0]                round;
    logic [127:0]              round_key;
    logic [32*SBOX_LANES-1:0]  sboxw;
    logic [32*SBOX_LANES-1:0]  new_sboxw;

    modport master (
        output next, keylen, block, round_key, new_sboxw,
        input  new_block, ready, round, sboxw
    );

    modport slave (
        input  next, keylen, block, round_key, new_sboxw,
        output new_block, ready, round, sboxw
    );

endinterface

// File: rtl/aes_mixcolumn_word.sv
// MixColumns on a single 32-bit state column.
// Ports:
//   col    in   32  column, row 0 in bits [31:24]
//   mixed  out  32  column multiplied by the AES MixColumns matrix
module aes_mixcolumn_word
    import aes_encipher_core_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = col;

    assign mixed = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                    b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                    b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                    gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128/256 encipher datapath with its own round FSM.
// Parameters:
//   SBOX_LANES  32-bit words substituted per cycle (1, 2 or 4)
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         aes_encipher_core_if slave: next/keylen/block in,
//               new_block/ready out, round out / round_key in,
//               sboxw out / new_sboxw in
// Configuration macro AES_ENC_MIXCOL_REG_EN: when defined, each main
// round is split into MAIN_A (ShiftRows + MixColumns into a pipeline
// register) and MAIN_B (AddRoundKey), adding one cycle per main round.
module aes_encipher_core
    import aes_encipher_core_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input logic             clk,
    input logic             reset,
    aes_encipher_core_if.slave bus
);

    localparam int         SBOX_CYCLES = 4 / SBOX_LANES;
    localparam logic [1:0] LAST_WORD   = 2'(SBOX_CYCLES - 1);

`ifdef AES_ENC_MIXCOL_REG_EN
    localparam state_t MAIN_ENTRY = ST_MAIN_A;
`else
    localparam state_t MAIN_ENTRY = ST_MAIN;
`endif

    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
            $error("aes_encipher_core: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    state_t                      state_reg;
    logic                        keylen_reg;
    logic [127:0]                in_block_reg;
    logic [127:0]                block_reg;
    logic [3:0]                  round_reg;
    logic [1:0]                  word_ctr;
`ifdef AES_ENC_MIXCOL_REG_EN
    logic [127:0]                mix_reg;
`endif

    logic [3:0]                  nr;
    aes_bytes_t                  shifted;
    logic [127:0]                shifted_flat;
    logic [127:0]                mixed;
    logic [0:3][31:0]            cur_words;
    logic [0:3][31:0]            upd_words;
    logic [SBOX_LANES-1:0][31:0] sbox_in;
    logic [SBOX_LANES-1:0][31:0] sbox_out;
    logic [1:0]                  sbox_idx;

    assign nr = (keylen_reg == KEYLEN_256) ? NR_256 : NR_128;

    assign shifted      = shiftrows(block_reg);
    assign shifted_flat = shifted;

    for (genvar c = 0; c < 4; c++) begin : g_mixcol
        aes_mixcolumn_word u_mix (
            .col   (shifted_flat[127 - 32*c -: 32]),
            .mixed (mixed[127 - 32*c -: 32])
        );
    end

    // Lane i handles word word_ctr*L + i; the substituted words are
    // merged back into the state in place, untouched words pass through.
    always_comb begin
        cur_words = block_reg;
        upd_words = block_reg;
        sbox_in   = '0;
        sbox_idx  = '0;
        for (int i = 0; i < SBOX_LANES; i++) begin
            sbox_idx            = 2'(int'(word_ctr) * SBOX_LANES + i);
            sbox_in[i]          = cur_words[sbox_idx];
            upd_words[sbox_idx] = sbox_out[i];
        end
    end

    assign sbox_out = bus.new_sboxw;

    // The shared S-box bank only sees activity during SBOX cycles.
    assign bus.sboxw     = (state_reg == ST_SBOX) ? sbox_in : '0;
    assign bus.round     = round_reg;
    assign bus.new_block = block_reg;
    assign bus.ready     = (state_reg == ST_IDLE);

    // Round FSM. The plaintext is latched on accept but only enters the
    // state register in INIT, so new_block keeps the previous
    // ciphertext until then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            keylen_reg   <= KEYLEN_128;
            in_block_reg <= '0;
            block_reg    <= '0;
            round_reg    <= '0;
            word_ctr     <= '0;
`ifdef AES_ENC_MIXCOL_REG_EN
            mix_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.next) begin
                        keylen_reg   <= bus.keylen;
                        in_block_reg <= bus.block;
                        round_reg    <= 4'd0;
                        word_ctr     <= 2'd0;
                        state_reg    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    block_reg <= in_block_reg ^ bus.round_key;
                    round_reg <= 4'd1;
                    word_ctr  <= 2'd0;
                    state_reg <= ST_SBOX;
                end
                ST_SBOX: begin
                    block_reg <= upd_words;
                    if (word_ctr == LAST_WORD) begin
                        word_ctr  <= 2'd0;
                        state_reg <= (round_reg == nr) ? ST_FINAL : MAIN_ENTRY;
                    end else begin
                        word_ctr <= word_ctr + 2'd1;
                    end
                end
`ifdef AES_ENC_MIXCOL_REG_EN
                ST_MAIN_A: begin
                    mix_reg   <= mixed;
                    state_reg <= ST_MAIN_B;
                end
                ST_MAIN_B: begin
                    block_reg <= mix_reg ^ bus.round_key;
                    round_reg <= round_reg + 4'd1;
                    state_reg <= ST_SBOX;
                end
`else
                ST_MAIN: begin
                    block_reg <= mixed ^ bus.round_key;
                    round_reg <= round_reg + 4'd1;
                    state_reg <= ST_SBOX;
                end
`endif
                ST_FINAL: begin
                    block_reg <= shifted_flat ^ bus.round_key;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
